// File: rtl/ram_fifo_ctrl_pkg.sv
// ram_fifo_ctrl_pkg: shared sizing helpers for the RAM-backed FIFO controller
// and its RAM macro.
//   CLOG2      : ceil(log2(n)), address/counter width helper
//   obuf_depth : output-buffer entries needed to cover the RAM read latency
package ram_fifo_ctrl_pkg;

  function automatic int CLOG2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // One slot per in-flight read plus the word currently being presented,
  // so reads can be issued every cycle without a bubble while m_ready is high.
  function automatic int obuf_depth(input int ram_delay);
    return ram_delay + 1;
  endfunction

endpackage

// File: rtl/ip_ram.sv
// ip_ram: simple dual-port RAM, write port A, read port B.
//   clka/ena/wea/addra/dina : synchronous write port
//   clkb/enb/addrb/doutb    : read port, doutb valid RAM_DELAY (1 or 2) cycles
//                             after the enb cycle
// Contents are never reset. No read-during-write bypass: the controller never
// reads an address in the cycle it is written.
module ip_ram
  import ram_fifo_ctrl_pkg::*;
#(
  parameter int RAM_DEEP          = 300,
  parameter int RAM_DATA_BITWIDTH = 8,
  parameter int RAM_DELAY         = 2,
  localparam int AW               = CLOG2(RAM_DEEP)
) (
  input  logic                         clka,
  input  logic                         ena,
  input  logic                         wea,
  input  logic [AW-1:0]                addra,
  input  logic [RAM_DATA_BITWIDTH-1:0] dina,
  input  logic                         clkb,
  input  logic                         enb,
  input  logic [AW-1:0]                addrb,
  output logic [RAM_DATA_BITWIDTH-1:0] doutb
);

  logic [RAM_DATA_BITWIDTH-1:0] mem [RAM_DEEP];
  logic [RAM_DATA_BITWIDTH-1:0] rd_q;

  always_ff @(posedge clka) begin
    if (ena && wea) mem[addra] <= dina;
  end

  always_ff @(posedge clkb) begin
    if (ena && enb) rd_q <= mem[addrb];
  end

  generate
    if (RAM_DELAY >= 2) begin : g_d2
      logic [RAM_DATA_BITWIDTH-1:0] rd_q2;
      always_ff @(posedge clkb) rd_q2 <= rd_q;
      assign doutb = rd_q2;
    end else begin : g_d1
      assign doutb = rd_q;
    end
  endgenerate

endmodule

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: FIFO built on a latency-RAM_DELAY RAM plus a small output
// buffer that hides the read latency.
//   clk, rst_n              : clock, async active-low reset
//   s_valid/s_ready/s_data  : write side, word taken when s_valid & s_ready
//   m_valid/m_ready/m_data  : read side, word consumed when m_valid & m_ready
//   count                   : words held (RAM + in flight + output buffer)
//   full/empty              : count at capacity / count zero
module ram_fifo_ctrl
  import ram_fifo_ctrl_pkg::*;
#(
  parameter int FIFO_DEEP      = 300,
  parameter int DATA_BITWIDTH  = 8,
  parameter int RAM_DELAY      = 2,
  localparam int CNT_BITWIDTH  = CLOG2(FIFO_DEEP + RAM_DELAY + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DATA_BITWIDTH-1:0] s_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DATA_BITWIDTH-1:0] m_data,
  output logic [CNT_BITWIDTH-1:0]  count,
  output logic                     full,
  output logic                     empty
);

  localparam int ADDR_BITWIDTH = CLOG2(FIFO_DEEP);
  localparam int OBUF_DEPTH    = obuf_depth(RAM_DELAY);
  localparam int OIDX_W        = CLOG2(OBUF_DEPTH);
  localparam int OCNT_W        = CLOG2(OBUF_DEPTH + 1);

  logic [ADDR_BITWIDTH-1:0] wr_ptr, rd_ptr;
  logic [CNT_BITWIDTH-1:0]  ram_cnt;
  logic [RAM_DELAY:1]       vld_pipe;
  logic [OCNT_W-1:0]        obuf_cnt, inflight_cnt;
  logic [OCNT_W:0]          occ;
  logic [OIDX_W-1:0]        obuf_wr_idx, obuf_rd_idx;
  logic [DATA_BITWIDTH-1:0] obuf [OBUF_DEPTH];
  logic [DATA_BITWIDTH-1:0] ram_dout;
  logic                     accept, pop, rd_en, ret;

  function automatic logic [ADDR_BITWIDTH-1:0] ptr_inc(input logic [ADDR_BITWIDTH-1:0] p);
    return (p == ADDR_BITWIDTH'(FIFO_DEEP - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [OIDX_W-1:0] oidx_inc(input logic [OIDX_W-1:0] p);
    return (p == OIDX_W'(OBUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign s_ready = (ram_cnt < CNT_BITWIDTH'(FIFO_DEEP));
  assign m_valid = (obuf_cnt != '0);
  assign m_data  = obuf[obuf_rd_idx];
  assign accept  = s_valid & s_ready;
  assign pop     = m_valid & m_ready;
  assign ret     = vld_pipe[RAM_DELAY];
  assign full    = (count == CNT_BITWIDTH'(FIFO_DEEP + RAM_DELAY + 1));
  assign empty   = (count == '0);

  always_comb begin
    inflight_cnt = '0;
    for (int i = 1; i <= RAM_DELAY; i++) inflight_cnt = inflight_cnt + OCNT_W'(vld_pipe[i]);
  end

  // Reserve an output-buffer slot for every read in flight; a pop this cycle
  // frees one, which is what keeps the read stream bubble-free.
  assign occ   = {1'b0, obuf_cnt} + {1'b0, inflight_cnt} - (OCNT_W + 1)'(pop);
  assign rd_en = (ram_cnt != '0) && (occ < (OCNT_W + 1)'(OBUF_DEPTH));

  ip_ram #(
    .RAM_DEEP          (FIFO_DEEP),
    .RAM_DATA_BITWIDTH (DATA_BITWIDTH),
    .RAM_DELAY         (RAM_DELAY)
  ) u_ram (
    .clka  (clk),
    .ena   (1'b1),
    .wea   (accept),
    .addra (wr_ptr),
    .dina  (s_data),
    .clkb  (clk),
    .enb   (rd_en),
    .addrb (rd_ptr),
    .doutb (ram_dout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ram_cnt     <= '0;
      vld_pipe    <= '0;
      obuf_cnt    <= '0;
      obuf_wr_idx <= '0;
      obuf_rd_idx <= '0;
      count       <= '0;
    end else begin
      if (accept) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_en)  rd_ptr <= ptr_inc(rd_ptr);
      ram_cnt <= ram_cnt + CNT_BITWIDTH'(accept) - CNT_BITWIDTH'(rd_en);
      vld_pipe[1] <= rd_en;
      for (int i = 2; i <= RAM_DELAY; i++) vld_pipe[i] <= vld_pipe[i-1];
      if (ret) obuf_wr_idx <= oidx_inc(obuf_wr_idx);
      if (pop) obuf_rd_idx <= oidx_inc(obuf_rd_idx);
      obuf_cnt <= obuf_cnt + OCNT_W'(ret) - OCNT_W'(pop);
      count    <= count + CNT_BITWIDTH'(accept) - CNT_BITWIDTH'(pop);
    end
  end

  // Buffer storage needs no reset; obuf_cnt qualifies it.
  always_ff @(posedge clk) begin
    if (ret) obuf[obuf_wr_idx] <= ram_dout;
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
module tb_ram_fifo_ctrl;
  localparam int CW  = 9;
  localparam int CAP = 303;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          m_ready = 1'b0;
  logic [7:0]    s_data = '0;
  logic          s_ready, m_valid, full, empty;
  logic [7:0]    m_data;
  logic [CW-1:0] count;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic [7:0] exp_q[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = '0;

  ram_fifo_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Scoreboard: accepted words are queued, popped words compared in order;
  // a stalled word must stay put until it is taken.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", m_valid, 1'b1);
        chk("hold_data", m_data, prev_data);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("unexpected_word", 1'b1, 1'b0);
        else chk("rd_data", m_data, exp_q.pop_front());
      end
      if (s_valid && s_ready) exp_q.push_back(s_data);
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    do begin
      @(posedge clk); #2;
      n++;
    end while ((exp_q.size() != 0 || m_valid) && n < 3000);
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", chk_cnt);
    $fatal(1);
  end

  initial begin
    int acc, cyc;
    logic [3:0] bp;
    bp = 4'b1001;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_s_ready", s_ready, 1);
    @(posedge clk); #1 rst_n = 1'b1;

    // latency: write 0x5A in cycle 0, m_valid first high in cycle 4
    @(posedge clk); #1;
    s_valid = 1'b1; s_data = 8'h5A; m_ready = 1'b1;
    @(posedge clk); #1 s_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("lat_m_valid_c%0d", k), m_valid, (k == 4));
      if (k == 1) chk("lat_count_c1", count, 1);
      if (k < 4) @(posedge clk);
    end
    @(posedge clk); @(negedge clk);
    chk("lat_empty", empty, 1);
    chk("lat_count0", count, 0);

    // fill with no reader: 303 words fit, then writes are refused
    @(posedge clk); #1 m_ready = 1'b0;
    for (int i = 0; i < CAP; i++) begin
      s_valid = 1'b1; s_data = 8'(i % 256);
      @(negedge clk);
      chk("fill_s_ready", s_ready, 1);
      @(posedge clk); #1;
    end
    s_data = 8'hEE;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("full_s_ready", s_ready, 0);
      chk("full_count", count, CAP);
      chk("full_flag", full, 1);
      chk("full_empty", empty, 0);
      @(posedge clk); #1;
    end
    s_valid = 1'b0; m_ready = 1'b1;
    wait_drain("fill_drain");
    @(negedge clk);
    chk("fill_drain_count", count, 0);

    // throughput: one in, one out every cycle, count pinned at 4
    @(posedge clk); #1;
    s_valid = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 600; i++) begin
      s_data = 8'(i * 7 + 3);
      @(negedge clk);
      if (i >= 8) begin
        chk("tput_pop", m_valid & m_ready, 1);
        chk("tput_count", count, 4);
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    wait_drain("tput_drain");

    // backpressure hold: m_ready 1-0-0-1 while data is waiting
    @(posedge clk); #1 m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = 8'hA1 + 8'(i);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    cyc = 0;
    while (!m_valid && cyc < 20) begin @(posedge clk); #1; cyc++; end
    chk("bp_m_valid", m_valid, 1);
    for (int k = 0; k < 16; k++) begin
      m_ready = bp[3 - (k % 4)];
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
    wait_drain("bp_drain");

    // random traffic across pointer wrap, alternating reader speed
    acc = 0; cyc = 0;
    @(posedge clk); #1;
    while (acc < 1000 && cyc < 20000) begin
      s_valid = 1'($urandom_range(0, 1));
      s_data  = 8'($urandom);
      m_ready = ($urandom_range(0, 99) < (((cyc / 200) % 2) != 0 ? 85 : 25));
      @(negedge clk);
      if (s_valid && s_ready) acc++;
      chk("rand_count_le_cap", (count <= CW'(CAP)), 1);
      @(posedge clk); #1;
      cyc++;
    end
    chk("rand_accepted", acc, 1000);
    s_valid = 1'b0; m_ready = 1'b1;
    wait_drain("rand_drain");

    // reset mid-stream: 10 words held with a read in flight
    @(posedge clk); #1 m_ready = 1'b0;
    for (int i = 0; i < 11; i++) begin
      s_valid = 1'b1; s_data = 8'h80 + 8'(i);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    m_ready = 1'b1;
    @(posedge clk); #1 m_ready = 1'b0;
    @(negedge clk);
    chk("mid_count", count, 10);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_s_ready", s_ready, 1);
    chk("mid_rst_empty", empty, 1);
    @(posedge clk); #1 rst_n = 1'b1;
    s_valid = 1'b1; s_data = 8'h11; m_ready = 1'b1;
    @(posedge clk); #1 s_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("mid_m_valid_c%0d", k), m_valid, (k == 4));
      if (k == 4) chk("mid_first_word", m_data, 8'h11);
      if (k < 4) @(posedge clk);
    end
    wait_drain("mid_drain");
    @(negedge clk);
    chk("final_empty", empty, 1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
